// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module  : fb_pixel_writer
// Brief   : Three-stage pixel sink. It clips (x,y,color) pixels to the framebuffer,
//           converts each to a linear address and writes it to memory with backpressure.
// Revision: 1.0  initial release
// ============================================================================
module fb_pixel_writer #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int X_BITS     = $clog2(FB_WIDTH) + 1,
    parameter int Y_BITS     = $clog2(FB_HEIGHT) + 1,
    parameter int COLOR_BITS = 12,
    parameter int ADDR_BITS  = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X_BITS-1:0]     in_x,
    input  logic [Y_BITS-1:0]     in_y,
    input  logic [COLOR_BITS-1:0] in_color,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [COLOR_BITS-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  frame_done,
    output logic                  busy,
    output logic [CNT_BITS-1:0]   pix_written,
    output logic [CNT_BITS-1:0]   pix_clipped
);

    localparam logic [X_BITS:0]    c_fb_width_x  = (X_BITS + 1)'(FB_WIDTH);
    localparam logic [Y_BITS:0]    c_fb_height_y = (Y_BITS + 1)'(FB_HEIGHT);
    localparam logic [ADDR_BITS-1:0] c_fb_width_a = ADDR_BITS'(FB_WIDTH);

    logic                  r_s1_v, r_s1_in, r_s1_last;
    logic [X_BITS-1:0]     r_s1_x;
    logic [Y_BITS-1:0]     r_s1_y;
    logic [COLOR_BITS-1:0] r_s1_data;

    logic                  r_s2_v, r_s2_in, r_s2_last;
    logic [ADDR_BITS-1:0]  r_s2_addr;
    logic [COLOR_BITS-1:0] r_s2_data;

    logic                  r_s3_v, r_s3_in, r_s3_last;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic [COLOR_BITS-1:0] r_mem_data;
    logic                  r_frame_done;
    logic [CNT_BITS-1:0]   r_pix_written, r_pix_clipped;

    logic                  w_inside;
    logic [ADDR_BITS-1:0]  w_addr;
    logic                  w_s3_retire, w_s3_free, w_s2_free, w_s1_free, w_wr_accept;

    assign w_inside = ({1'b0, in_x} < c_fb_width_x) && ({1'b0, in_y} < c_fb_height_y);
    assign w_addr   = ADDR_BITS'(r_s1_y) * c_fb_width_a + ADDR_BITS'(r_s1_x);

    // Clipped pixels never touch memory, so they leave S3 without waiting on mem_ready.
    assign w_s3_retire = r_s3_v && (!r_s3_in || mem_ready);
    assign w_s3_free   = !r_s3_v || w_s3_retire;
    assign w_s2_free   = !r_s2_v || w_s3_free;
    assign w_s1_free   = !r_s1_v || w_s2_free;
    assign w_wr_accept = r_s3_v && r_s3_in && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v        <= 1'b0;
            r_s2_v        <= 1'b0;
            r_s3_v        <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
            r_frame_done  <= 1'b0;
            r_pix_written <= '0;
            r_pix_clipped <= '0;
        end else begin
            if (w_s1_free) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_x    <= in_x;
                    r_s1_y    <= in_y;
                    r_s1_data <= in_color;
                    r_s1_last <= in_last;
                    r_s1_in   <= w_inside;
                end
            end
            if (w_s2_free) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_addr <= w_addr;
                    r_s2_data <= r_s1_data;
                    r_s2_last <= r_s1_last;
                    r_s2_in   <= r_s1_in;
                end
            end
            if (w_s3_free) begin
                r_s3_v <= r_s2_v;
                if (r_s2_v) begin
                    r_mem_addr <= r_s2_addr;
                    r_mem_data <= r_s2_data;
                    r_s3_last  <= r_s2_last;
                    r_s3_in    <= r_s2_in;
                end
            end
            r_frame_done <= w_s3_retire && r_s3_last;
            if (w_wr_accept && (r_pix_written != '1))
                r_pix_written <= r_pix_written + CNT_BITS'(1);
            if (w_s3_retire && !r_s3_in && (r_pix_clipped != '1))
                r_pix_clipped <= r_pix_clipped + CNT_BITS'(1);
        end
    end

    assign in_ready    = !rst && w_s1_free;
    assign mem_we      = r_s3_v && r_s3_in;
    assign mem_addr    = r_mem_addr;
    assign mem_data    = r_mem_data;
    assign frame_done  = r_frame_done;
    assign busy        = r_s1_v || r_s2_v || r_s3_v;
    assign pix_written = r_pix_written;
    assign pix_clipped = r_pix_clipped;

endmodule
`default_nettype wire
